// File: rtl/inst_buffer.sv
// inst_buffer: fetch-to-decode instruction queue. Compacts valid fetch slots
// into a circular FIFO and offers the oldest DECODE_NUM entries to decode.
`default_nettype none

module inst_buffer #(
  parameter int FETCH_NUM  = 4,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int DECODE_NUM = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [FETCH_NUM-1:0]             inst_valid,
  input  logic [FETCH_NUM*INST_WIDTH-1:0]  inst_value,
  output logic                             buffer_full,
  output logic [DECODE_NUM-1:0]            out_valid,
  output logic [DECODE_NUM*INST_WIDTH-1:0] out_inst,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_THR = CW'(DEPTH - FETCH_NUM);
  localparam logic [CW-1:0] DEC_MAX  = CW'(DECODE_NUM);

  logic [INST_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  enq;
  logic [CW-1:0]         n_in;
  logic [CW-1:0]         n_out;
  logic [FETCH_NUM-1:0]  wr_en;
  logic [PW-1:0]         wr_idx [FETCH_NUM];

  assign buffer_full = (count_q > FULL_THR);
  assign count       = count_q;

  // Each valid slot lands at tail plus the number of valid slots below it.
  always_comb begin
    enq  = ~buffer_full & ~flush;
    n_in = '0;
    for (int i = 0; i < FETCH_NUM; i++) begin
      wr_idx[i] = tail_q + n_in[PW-1:0];
      wr_en[i]  = enq & inst_valid[i];
      if (inst_valid[i]) n_in = n_in + CW'(1);
    end
  end

  always_comb begin
    n_out = '0;
    if (out_ready) n_out = (count_q > DEC_MAX) ? DEC_MAX : count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + n_out[PW-1:0];
      count_d = count_q - n_out;
      if (enq) begin
        tail_d  = tail_q + n_in[PW-1:0];
        count_d = count_q + n_in - n_out;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < FETCH_NUM; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= inst_value[i*INST_WIDTH +: INST_WIDTH];
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    for (int j = 0; j < DECODE_NUM; j++) begin
      out_valid[j] = (count_q > CW'(j));
      if (out_valid[j]) out_inst[j*INST_WIDTH +: INST_WIDTH] = mem_q[head_q + PW'(j)];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: stimulus pushes accepted instructions,
// a negedge monitor compares every presented lane against the queue.
`default_nettype none

module tb_inst_buffer;

  localparam int FN = 4;
  localparam int W  = 32;
  localparam int DN = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic [FN-1:0]   inst_valid = '0;
  logic [FN*W-1:0] inst_value = '0;
  logic            buffer_full;
  logic [DN-1:0]   out_valid;
  logic [DN*W-1:0] out_inst;
  logic            out_ready = 1'b0;
  logic [4:0]      count;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seq = 32'h1000_0000;

  inst_buffer #(.FETCH_NUM(FN), .INST_WIDTH(W), .DEPTH(16), .DECODE_NUM(DN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .inst_valid(inst_valid), .inst_value(inst_value),
    .buffer_full(buffer_full), .out_valid(out_valid), .out_inst(out_inst),
    .out_ready(out_ready), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each valid lane with the queue, pop what decode consumes.
  always @(negedge clock) begin
    if (reset && !flush) begin
      for (int j = 0; j < DN; j++) begin
        if (out_valid[j]) begin
          if (exp_q.size() > j) check("lane_value", {32'h0, out_inst[j*W +: W]}, {32'h0, exp_q[j]});
          else check("lane_unexpected", {32'h0, out_inst[j*W +: W]}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("lane_zero", {32'h0, out_inst[j*W +: W]}, 64'h0);
        end
      end
      if (out_ready)
        for (int j = 0; j < DN; j++)
          if (out_valid[j] && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // One clock of stimulus; the model decides acceptance and checks registers after the edge.
  task automatic cycle(input logic [FN-1:0] mask, input logic [FN*W-1:0] vals,
                       input logic rdy, input logic fl);
    int n_in, n_out;
    bit full;
    inst_valid = mask;
    inst_value = vals;
    out_ready  = rdy;
    flush      = fl;
    full  = (mcount > 12);
    n_in  = 0;
    n_out = rdy ? ((mcount > DN) ? DN : mcount) : 0;
    if (!full && !fl)
      for (int i = 0; i < FN; i++)
        if (mask[i]) begin
          n_in++;
          exp_q.push_back(vals[i*W +: W]);
        end
    @(posedge clock);
    #1;
    if (fl) exp_q.delete();
    mcount = fl ? 0 : mcount + n_in - n_out;
    inst_valid = '0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    check("count", {59'h0, count}, 64'(mcount));
    check("buffer_full", {63'h0, buffer_full}, {63'h0, mcount > 12});
    check("out_valid", {62'h0, out_valid}, (mcount >= 2) ? 64'h3 : (mcount == 1) ? 64'h1 : 64'h0);
  endtask

  function automatic logic [FN*W-1:0] seq_pack(input logic [W-1:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic drain();
    int guard = 0;
    while (mcount > 0 && guard < 40) begin
      cycle('0, '0, 1'b1, 1'b0);
      guard++;
    end
    check("drain_done", 64'(mcount), 64'h0);
    check("drain_queue", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and asynchronous reset mid-traffic
    #12;
    check("reset_count", {59'h0, count}, 64'h0);
    check("reset_valid", {62'h0, out_valid}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cycle(4'b1111, seq_pack(32'h0000_0010), 1'b0, 1'b0);
    cycle(4'b0111, seq_pack(32'h0000_0020), 1'b0, 1'b0);
    check("pre_reset_count", {59'h0, count}, 64'd7);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", {59'h0, count}, 64'h0);
    check("async_valid", {62'h0, out_valid}, 64'h0);
    check("async_inst", {out_inst}, 64'h0);
    check("async_full", {63'h0, buffer_full}, 64'h0);
    exp_q.delete();
    mcount = 0;
    @(negedge clock);
    reset = 1'b1;
    cycle(4'b1111, seq_pack(32'h0000_0030), 1'b0, 1'b0);
    check("post_reset_count", {59'h0, count}, 64'd4);
    drain();

    // Compaction of a sparse mask
    cycle(4'b1100, {32'hAAAA0003, 32'hAAAA0002, 32'hDEAD0001, 32'hDEAD0000}, 1'b0, 1'b0);
    check("compact_lane0", {32'h0, out_inst[31:0]}, 64'hAAAA0002);
    check("compact_lane1", {32'h0, out_inst[63:32]}, 64'hAAAA0003);
    check("compact_count", {59'h0, count}, 64'd2);
    drain();

    // Fill to the threshold, drop packs while full, then drain one pair
    for (int k = 0; k < 3; k++) cycle(4'b1111, seq_pack(32'h0000_0100 + 32'(k * 4)), 1'b0, 1'b0);
    cycle(4'b0001, seq_pack(32'h0000_0200), 1'b0, 1'b0);
    check("fill_count", {59'h0, count}, 64'd13);
    check("fill_full", {63'h0, buffer_full}, 64'h1);
    cycle(4'b1111, seq_pack(32'hBAD0_0000), 1'b0, 1'b0);
    cycle(4'b1111, seq_pack(32'hBAD0_0010), 1'b0, 1'b0);
    check("drop_count", {59'h0, count}, 64'd13);
    cycle('0, '0, 1'b1, 1'b0);
    check("unfull_count", {59'h0, count}, 64'd11);
    check("unfull_full", {63'h0, buffer_full}, 64'h0);
    drain();

    // Concurrent streaming across the pointer wrap
    for (int k = 0; k < 20; k++) begin
      cycle(4'b1111, seq_pack(seq), 1'b1, 1'b0);
      seq = seq + 32'd4;
      if (k == 0) check("stream_c1", {59'h0, count}, 64'd4);
      if (k == 1) check("stream_c2", {59'h0, count}, 64'd6);
    end
    drain();

    // Flush beats same-cycle enqueue and dequeue
    cycle(4'b1111, seq_pack(32'h0000_0300), 1'b0, 1'b0);
    cycle(4'b1111, seq_pack(32'h0000_0310), 1'b0, 1'b0);
    cycle(4'b0001, seq_pack(32'h0000_0320), 1'b0, 1'b0);
    check("preflush_count", {59'h0, count}, 64'd9);
    cycle(4'b1111, seq_pack(32'hBAD0_0100), 1'b1, 1'b1);
    check("flush_count", {59'h0, count}, 64'h0);
    check("flush_valid", {62'h0, out_valid}, 64'h0);
    cycle(4'b0011, {32'h0, 32'h0, 32'h5555_0001, 32'h5555_0000}, 1'b0, 1'b0);
    check("postflush_lane0", {32'h0, out_inst[31:0]}, 64'h5555_0000);
    check("postflush_lane1", {32'h0, out_inst[63:32]}, 64'h5555_0001);
    drain();

    // Partial drain of a single entry
    cycle(4'b0100, {32'h0, 32'h7777_0002, 32'h0, 32'h0}, 1'b0, 1'b0);
    check("partial_valid", {62'h0, out_valid}, 64'h1);
    check("partial_lane0", {32'h0, out_inst[31:0]}, 64'h7777_0002);
    cycle('0, '0, 1'b1, 1'b0);
    check("partial_count", {59'h0, count}, 64'h0);
    check("partial_inst", out_inst, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_buffer.md
# inst_buffer

- Fetch queue between `inst_fetch` and decode.
- Accepts a pack of up to FETCH_NUM instructions per cycle with a per-slot valid mask. Valid slots are compacted and stored in program order in a circular FIFO.
- Presents up to DECODE_NUM oldest instructions per cycle to decode.
- Drives `buffer_full` back to fetch to throttle requests; `flush` discards all contents on a redirect.

## Interface
- FETCH_NUM, 4, instruction slots per fetch pack (`INST_FETCH_NUM`)
- INST_WIDTH, 32, bits per instruction
- DEPTH, 16, queue entries; power of two, DEPTH >= 2*FETCH_NUM
- DECODE_NUM, 2, instructions offered to decode per cycle; DECODE_NUM <= FETCH_NUM
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `flush`  in  1  synchronous: discard all entries and any same-cycle enqueue
- `inst_valid`  in  FETCH_NUM  per-slot valid from fetch; any bit pattern legal
- `inst_value`  in  FETCH_NUM*INST_WIDTH  slot i at [i*INST_WIDTH +: INST_WIDTH]
- `buffer_full`  out  1  fewer than FETCH_NUM free entries
- `out_valid`  out  DECODE_NUM  lane j holds a valid instruction; thermometer-coded from lane 0
- `out_inst`  out  DECODE_NUM*INST_WIDTH  lane j = j-th oldest entry; 0 when lane invalid
- `out_ready`  in  1  decode consumes every lane with `out_valid` set this cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- **State:** storage array; `head` and `tail` pointers, each $clog2(DEPTH) bits wrapping modulo DEPTH; `count` register. No FSM; the occupancy counter governs.
- **Enqueue:**
  - Active when `~buffer_full`. n_in = popcount(`inst_valid`).
  - Valid slots are written to tail, tail+1, … in ascending slot order, with gaps removed (e.g. mask 4'b1100 writes slot2 at tail, slot3 at tail+1).
  - tail += n_in.
  - Pack presented while `buffer_full`=1 is dropped entirely; fetch already gates it.
- **Dequeue:**
  - n_out = `out_ready` ? min(count, DECODE_NUM) : 0.
  - head += n_out.
- **Occupancy:** count_next = count + n_in − n_out. Enqueue and dequeue in the same cycle are legal.
- **Outputs:**
  - `buffer_full` = (count > DEPTH − FETCH_NUM), decoded from registered count only; no path from `inst_valid`/`out_ready`.
  - `out_valid[j]` = (count > j).
  - `out_inst` lane j = storage[head+j] when valid, else 0. Purely a function of registers.
- **Flush:**
  - head, tail and count go to 0 at the clock edge.
  - Same-cycle enqueue and dequeue are ignored, so n_out is not counted.
  - Flush has priority over everything except reset.
- **Reset:**
  - Asynchronous assertion clears head, tail and count immediately. Storage need not be reset.
  - During reset: `buffer_full`=0, `out_valid`=0, `out_inst`=0, `count`=0.
  - Reset mid-operation loses all entries.
  - Deassertion is synchronised externally; the first enqueue is accepted on the first edge after release.

## Timing
- **Enqueue to output latency:** 1 cycle. An instruction written at edge k is visible on `out_*` after edge k. No combinational bypass when empty.
- **`buffer_full` update:** reflects the post-edge count in the same cycle the count changes. Fetch sees the new value one cycle after the enqueue that filled the queue.
- **Dequeue:** takes effect at the edge where `out_ready`=1. The next lanes appear immediately after that edge.
- **Throughput:** sustained DECODE_NUM instructions per cycle out, FETCH_NUM per cycle in, while not full.
- **Wrap-around:** pointer arithmetic is modulo DEPTH. A pack that straddles index DEPTH−1 → 0 is written contiguously across the wrap. Output lanes that straddle the wrap read correctly.
- **Boundaries:**
  - count never exceeds DEPTH and never underflows.
  - Full threshold: with DEPTH=16 and FETCH_NUM=4, `buffer_full`=1 at count ≥ 13.
  - Simultaneous last free entries filled and dequeued: count_next computed from both.

## Test plan
1. **Reset:** hold `reset`=0 mid-traffic with count=7 → `count`=0, `out_valid`=2'b00, `out_inst`=0, `buffer_full`=0 asynchronously. After release, enqueue mask 4'b1111 → `count`=4 next cycle.
2. **Compaction:** enqueue mask 4'b1100 with slot2=0xAAAA0002, slot3=0xAAAA0003 into an empty queue, `out_ready`=0 → next cycle `out_valid`=2'b11, lane0=0xAAAA0002, lane1=0xAAAA0003, `count`=2.
3. **Fill/full:**
   - Enqueue 4'b1111 for 3 cycles, then 4'b0001, `out_ready`=0 → `count`=13, `buffer_full`=1.
   - Further 4'b1111 packs are dropped and `count` stays 13.
   - One `out_ready` cycle → `count`=11, `buffer_full`=0.
4. **Concurrent in/out plus wrap:**
   - Stream 4'b1111 packs of sequential values with `out_ready`=1 for 20 cycles.
   - Required: values emerge in order with none lost or duplicated.
   - The pointers wrap past index 15 at least twice.
   - `count` grows by 2 per cycle until `buffer_full` throttles.
5. **Flush priority:** with count=9, assert `flush` with mask 4'b1111 and `out_ready`=1 → next cycle `count`=0, `out_valid`=0. A following enqueue of 4'b0011 yields lanes = those two values.
6. **Partial drain:** count=1, `out_ready`=1, no enqueue → `out_valid`=2'b01 before the edge; `count`=0 and `out_inst`=0 after the edge.
